// File: rtl/vga_pattern_gen.sv
// Test-pattern generator driven by external HS/VS: derives pixel position from the sync edges,
// draws one of four RGB332 patterns and reports whether the sync timing is locked.
module vga_pattern_gen #(
   parameter int unsigned H_START = 144,
   parameter int unsigned V_START = 35,
   parameter int unsigned H_TOTAL = 800,
   parameter int unsigned V_TOTAL = 525
) (
   input  logic       i_pix_clk,
   input  logic       i_rst,
   input  logic       i_hs,
   input  logic       i_vs,
   input  logic [1:0] i_sw,
   output logic [2:0] o_r,
   output logic [2:0] o_g,
   output logic [1:0] o_b,
   output logic       o_de,
   output logic [9:0] o_x,
   output logic [9:0] o_y,
   output logic       o_locked
);

   localparam logic [10:0] HFirst   = 11'(H_START);
   localparam logic [10:0] HLast    = 11'(H_START + 639);
   localparam logic [10:0] VFirst   = 11'(V_START);
   localparam logic [10:0] VLast    = 11'(V_START + 479);
   localparam logic [9:0]  HStart10 = 10'(H_START);
   localparam logic [9:0]  VStart10 = 10'(V_START);
   localparam logic [10:0] HTotal11 = 11'(H_TOTAL);
   localparam logic [10:0] VTotal11 = 11'(V_TOTAL);
   localparam logic [7:0]  White    = 8'b111_111_11;

   logic       r_hs_d, r_vs_d;
   logic [9:0] r_hcnt, r_vcnt;
   logic [1:0] r_pat;
   logic       r_frame_bad, r_armed, r_locked;
   logic [1:0] r_good_cnt;
   logic       r_de;
   logic [9:0] r_x, r_y;
   logic [7:0] r_rgb;

   logic       w_hs_fall, w_vs_fall, w_vis;
   logic [9:0] w_x, w_y;
   logic [2:0] w_bar;
   logic [7:0] w_rgb;
   logic       w_line_fail, w_frame_good;
   logic       w_frame_bad_d, w_armed_d, w_locked_d;
   logic [1:0] w_good_cnt_d;

   assign w_hs_fall = r_hs_d & ~i_hs;
   assign w_vs_fall = r_vs_d & ~i_vs;

   assign w_vis = ({1'b0, r_hcnt} >= HFirst) && ({1'b0, r_hcnt} <= HLast) &&
                  ({1'b0, r_vcnt} >= VFirst) && ({1'b0, r_vcnt} <= VLast);
   assign w_x   = r_hcnt - HStart10;
   assign w_y   = r_vcnt - VStart10;

   always_comb begin
      w_bar = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (w_x >= 10'(80 * i)) w_bar = 3'(i);
      end
   end

   always_comb begin
      w_rgb = 8'd0;
      unique case (r_pat)
         2'd0: begin
            unique case (w_bar)
               3'd0: w_rgb = 8'b111_111_11;
               3'd1: w_rgb = 8'b111_111_00;
               3'd2: w_rgb = 8'b000_111_11;
               3'd3: w_rgb = 8'b000_111_00;
               3'd4: w_rgb = 8'b111_000_11;
               3'd5: w_rgb = 8'b111_000_00;
               3'd6: w_rgb = 8'b000_000_11;
               3'd7: w_rgb = 8'b000_000_00;
            endcase
         end
         2'd1: w_rgb = (w_x[5] ^ w_y[5]) ? White : 8'd0;
         2'd2: w_rgb = {w_x[9:7], w_y[8:6], w_x[6:5]};
         2'd3: w_rgb = ((w_x == 10'd0) || (w_x == 10'd639) ||
                        (w_y == 10'd0) || (w_y == 10'd479)) ? White : 8'd0;
      endcase
   end

   // A disarmed check skips the partial line that follows reset or a loss of lock.
   assign w_line_fail  = w_hs_fall & r_armed & (({1'b0, r_hcnt} + 11'd1) != HTotal11);
   assign w_frame_good = (({1'b0, r_vcnt} + 11'd1) == VTotal11) & ~r_frame_bad & ~w_line_fail;

   always_comb begin
      w_frame_bad_d = r_frame_bad;
      w_good_cnt_d  = r_good_cnt;
      w_locked_d    = r_locked;
      w_armed_d     = r_armed | w_hs_fall;
      if (w_vs_fall) begin
         w_frame_bad_d = 1'b0;
         if (w_frame_good) begin
            w_good_cnt_d = (r_good_cnt == 2'd2) ? 2'd2 : r_good_cnt + 2'd1;
            if (r_good_cnt != 2'd0) w_locked_d = 1'b1;
         end else begin
            w_good_cnt_d = 2'd0;
            w_locked_d   = 1'b0;
         end
      end else if (w_line_fail) begin
         w_frame_bad_d = 1'b1;
      end
      if (w_line_fail) w_locked_d = 1'b0;
      if (r_locked && !w_locked_d) w_armed_d = 1'b0;
   end

   always_ff @(posedge i_pix_clk) begin
      if (i_rst) begin
         r_hs_d      <= 1'b1;
         r_vs_d      <= 1'b1;
         r_hcnt      <= 10'd1023;
         r_vcnt      <= 10'd1023;
         r_pat       <= 2'd0;
         r_frame_bad <= 1'b0;
         r_good_cnt  <= 2'd0;
         r_armed     <= 1'b0;
         r_locked    <= 1'b0;
         r_de        <= 1'b0;
         r_x         <= 10'd0;
         r_y         <= 10'd0;
         r_rgb       <= 8'd0;
      end else begin
         r_hs_d      <= i_hs;
         r_vs_d      <= i_vs;
         r_frame_bad <= w_frame_bad_d;
         r_good_cnt  <= w_good_cnt_d;
         r_armed     <= w_armed_d;
         r_locked    <= w_locked_d;
         if (w_vs_fall) r_pat <= i_sw;

         if (w_hs_fall)                r_hcnt <= 10'd0;
         else if (r_hcnt != 10'd1023)  r_hcnt <= r_hcnt + 10'd1;
         if (w_vs_fall)                             r_vcnt <= 10'd0;
         else if (w_hs_fall && r_vcnt != 10'd1023)  r_vcnt <= r_vcnt + 10'd1;

         r_de <= w_vis;
         if (w_vis) begin
            r_x   <= w_x;
            r_y   <= w_y;
            r_rgb <= w_rgb;
         end else begin
            r_rgb <= 8'd0;
         end
      end
   end

   assign o_r      = r_rgb[7:5];
   assign o_g      = r_rgb[4:2];
   assign o_b      = r_rgb[1:0];
   assign o_de     = r_de;
   assign o_x      = r_x;
   assign o_y      = r_y;
   assign o_locked = r_locked;

endmodule
